// File: rtl/ir_pkg.sv
// Shared types and default sizing for the instruction assembler and its queue.
package ir_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CHUNKS = 2;
  localparam int DEF_DEPTH  = 2;

endpackage

// File: rtl/ir_queue.sv
// Small circular FIFO holding assembled instructions; head reads as zero when empty.
module ir_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] head,
  output logic [3:0]       count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && (count < 4'(DEPTH));
  assign do_pop  = pop && (count != 4'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop) count <= count + 4'd1;
      else if (!do_push && do_pop) count <= count - 4'd1;
    end
  end

  assign head = (count != 4'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_assembler.sv
// Gathers DATA_W-wide chunks into CHUNKS-wide instructions and queues them.
// Optional head parity storage is enabled with the IR_PARITY_EN macro.
module instruction_assembler
  import ir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CHUNKS = DEF_CHUNKS,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [DATA_W-1:0]        I,
  input  logic                     IValid,
  output logic                     IReady,
  input  logic                     HighFirst,
  input  logic                     Flush,
  output logic [DATA_W*CHUNKS-1:0] IROut,
  output logic                     IRValid,
  input  logic                     IRReady,
  output logic [3:0]               Count,
  output logic                     IRParity
);

  localparam int IW = DATA_W * CHUNKS;
  localparam int CW = $clog2(CHUNKS);

  state_t          state, state_next;
  logic [CW-1:0]   idx, idx_next;
  logic            order, order_next;
  logic [IW-1:0]   asm_reg, asm_next;
  logic [IW-1:0]   merged;
  logic [CW-1:0]   slot;
  logic            eff_order;
  logic            last;
  logic            accept;
  logic            push;
  logic            pop;
  logic [3:0]      count;

  assign IReady  = (count < 4'(DEPTH));
  assign IRValid = (count != 4'd0);
  assign Count   = count;
  assign pop     = IRValid && IRReady && !Flush;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      idx     <= '0;
      order   <= 1'b0;
      asm_reg <= '0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      order   <= order_next;
      asm_reg <= asm_next;
    end
  end

  // The first chunk uses the live HighFirst; later chunks use the latched order.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    order_next = order;
    asm_next   = asm_reg;
    eff_order  = (state == IDLE) ? HighFirst : order;
    slot       = eff_order ? (CW'(CHUNKS - 1) - idx) : idx;
    merged     = (state == IDLE) ? '0 : asm_reg;
    for (int k = 0; k < CHUNKS; k++) begin
      if (CW'(k) == slot) merged[k*DATA_W +: DATA_W] = I;
    end
    last   = (idx == CW'(CHUNKS - 1));
    accept = IValid && IReady && !Flush;
    push   = accept && last;

    if (Flush) begin
      state_next = IDLE;
      idx_next   = '0;
    end else if (accept) begin
      asm_next = merged;
      if (state == IDLE) order_next = HighFirst;
      if (last) begin
        state_next = IDLE;
        idx_next   = '0;
      end else begin
        state_next = COLLECT;
        idx_next   = idx + 1'b1;
      end
    end
  end

`ifdef IR_PARITY_EN
  logic [IW:0] head;

  ir_queue #(.WIDTH(IW + 1), .DEPTH(DEPTH)) u_queue (
    .clock (Clock),
    .reset (Reset),
    .push  (push),
    .pop   (pop),
    .flush (Flush),
    .data  ({^merged, merged}),
    .head  (head),
    .count (count)
  );

  assign IROut    = head[IW-1:0];
  assign IRParity = head[IW];
`else
  logic [IW-1:0] head;

  ir_queue #(.WIDTH(IW), .DEPTH(DEPTH)) u_queue (
    .clock (Clock),
    .reset (Reset),
    .push  (push),
    .pop   (pop),
    .flush (Flush),
    .data  (merged),
    .head  (head),
    .count (count)
  );

  assign IROut    = head;
  assign IRParity = 1'b0;
`endif

endmodule
